// File: rtl/fsm_framer_pkg.sv
// Shared types for the packet framer: state encoding, error causes and the
// per-beat event classification used between decode and the state register.
package framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_DATA = 3'd2,
        ST_TAIL = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ORPHAN  = 2'd1,
        ERR_NESTED  = 2'd2,
        ERR_OVERLEN = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        EV_HOLD,
        EV_IDLE,
        EV_START,
        EV_SINGLE,
        EV_MORE,
        EV_END,
        EV_FAULT
    } event_t;

endpackage

// File: rtl/fsm_framer_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fsm_framer.sv
// Head/tail packet framer: tracks packet boundaries, reports completed
// packet lengths and framing errors, and keeps saturating event counters.
//
// state | meaning
// IDLE  | no packet open, waiting for a head beat
// HEAD  | head beat accepted, packet open
// DATA  | one or more middle beats accepted
// TAIL  | packet just completed (pkt_done pulses on entry)
// ERR   | framing error seen, waiting for a head beat to resync
module fsm_framer
    import framer_pkg::*;
#(
    parameter  int MAX_LEN = 16,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    input  logic             head,
    input  logic             tail,
    output logic [2:0]       state,
    output logic             pkt_done,
    output logic [LEN_W-1:0] pkt_len,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    state_t          state_q;
    logic [LEN_W-1:0] len_q;
    event_t          ev;
    err_code_t       ev_code;

    // Classify the current beat once so the register block and the counters
    // see exactly the same decision on the same edge.
    always_comb begin
        ev      = EV_HOLD;
        ev_code = ERR_NONE;
        if (!valid) begin
            if (state_q == ST_TAIL) ev = EV_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_TAIL, ST_ERR: begin
                    if (head) begin
                        ev = tail ? EV_SINGLE : EV_START;
                    end else if (state_q != ST_ERR) begin
                        ev      = EV_FAULT;
                        ev_code = ERR_ORPHAN;
                    end
                end
                ST_HEAD, ST_DATA: begin
                    if (head) begin
                        ev      = EV_FAULT;
                        ev_code = ERR_NESTED;
                    end else if (tail) begin
                        ev = EV_END;
                    end else if (len_q == LEN_W'(MAX_LEN)) begin
                        ev      = EV_FAULT;
                        ev_code = ERR_OVERLEN;
                    end else begin
                        ev = EV_MORE;
                    end
                end
                default: ev = EV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            pkt_done <= 1'b0;
            pkt_len  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            pkt_done <= 1'b0;
            err      <= 1'b0;
            case (ev)
                EV_IDLE: begin
                    state_q <= ST_IDLE;
                    len_q   <= '0;
                end
                EV_START: begin
                    state_q <= ST_HEAD;
                    len_q   <= LEN_W'(1);
                end
                EV_SINGLE: begin
                    state_q  <= ST_TAIL;
                    len_q    <= LEN_W'(1);
                    pkt_done <= 1'b1;
                    pkt_len  <= LEN_W'(1);
                end
                EV_MORE: begin
                    state_q <= ST_DATA;
                    len_q   <= len_q + 1'b1;
                end
                EV_END: begin
                    state_q  <= ST_TAIL;
                    len_q    <= len_q + 1'b1;
                    pkt_done <= 1'b1;
                    pkt_len  <= len_q + 1'b1;
                end
                EV_FAULT: begin
                    state_q  <= ST_ERR;
                    len_q    <= '0;
                    err      <= 1'b1;
                    err_code <= ev_code;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clock (clock),
        .reset (reset),
        .inc   ((ev == EV_SINGLE) || (ev == EV_END)),
        .count (pkt_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (ev == EV_FAULT),
        .count (err_count)
    );

endmodule

// File: tb/tb_fsm_framer.sv
// Drives two framer configurations with the same beats and compares every
// cycle against a rule-level packet model.
module tb_fsm_framer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic valid = 1'b0;
    logic head  = 1'b0;
    logic tail  = 1'b0;

    logic [2:0] a_state, b_state;
    logic       a_done, b_done, a_err, b_err;
    logic [4:0] a_plen;
    logic [2:0] b_plen;
    logic [1:0] a_code, b_code;
    logic [7:0] a_pc, a_ec;
    logic [1:0] b_pc, b_ec;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int st;
        int len;
        int done;
        int plen;
        int err;
        int code;
        int pc;
        int ec;
    } mdl_t;

    mdl_t ma, mb;

    always #5 clock = ~clock;

    fsm_framer dut_a (
        .clock(clock), .reset(reset), .valid(valid), .head(head), .tail(tail),
        .state(a_state), .pkt_done(a_done), .pkt_len(a_plen), .err(a_err),
        .err_code(a_code), .pkt_count(a_pc), .err_count(a_ec)
    );

    fsm_framer #(.MAX_LEN(4), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .valid(valid), .head(head), .tail(tail),
        .state(b_state), .pkt_done(b_done), .pkt_len(b_plen), .err(b_err),
        .err_code(b_code), .pkt_count(b_pc), .err_count(b_ec)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic mdl_t model_reset();
        mdl_t m;
        m.st = 0; m.len = 0; m.done = 0; m.plen = 0;
        m.err = 0; m.code = 0; m.pc = 0; m.ec = 0;
        return m;
    endfunction

    // Packet rules: 0 idle, 1 head, 2 data, 3 tail, 4 error.
    function automatic mdl_t step(mdl_t m, bit v, bit h, bit t, int maxl, int cmax);
        mdl_t n = m;
        int fault = 0;
        n.done = 0;
        n.err  = 0;
        if (!v) begin
            if (m.st == 3) n.st = 0;
            return n;
        end
        if (m.st == 0 || m.st == 3 || m.st == 4) begin
            if (h) begin
                n.len = 1;
                n.st  = t ? 3 : 1;
            end else if (m.st != 4) begin
                fault = 1;
            end
        end else begin
            if (h)                fault = 2;
            else if (t)           begin n.len = m.len + 1; n.st = 3; end
            else if (m.len == maxl) fault = 3;
            else                  begin n.len = m.len + 1; n.st = 2; end
        end
        if (fault != 0) begin
            n.st   = 4;
            n.err  = 1;
            n.code = fault;
            n.ec   = (m.ec < cmax) ? m.ec + 1 : cmax;
        end else if (n.st == 3 && (m.st != 3 || h)) begin
            n.done = 1;
            n.plen = n.len;
            n.pc   = (m.pc < cmax) ? m.pc + 1 : cmax;
        end
        return n;
    endfunction

    task automatic check_dut(input string p, input mdl_t m, input int st, input int done,
                             input int plen, input int e, input int code, input int pc, input int ec);
        check({p, "state"},    st,   m.st);
        check({p, "pkt_done"}, done, m.done);
        if (m.done != 0) check({p, "pkt_len"}, plen, m.plen);
        check({p, "err"},      e,    m.err);
        check({p, "err_code"}, code, m.code);
        check({p, "pkt_count"}, pc,  m.pc);
        check({p, "err_count"}, ec,  m.ec);
    endtask

    task automatic check_all();
        check_dut("a.", ma, int'(a_state), int'(a_done), int'(a_plen), int'(a_err),
                  int'(a_code), int'(a_pc), int'(a_ec));
        check_dut("b.", mb, int'(b_state), int'(b_done), int'(b_plen), int'(b_err),
                  int'(b_code), int'(b_pc), int'(b_ec));
    endtask

    task automatic beat(input bit v, input bit h, input bit t);
        valid = v;
        head  = h;
        tail  = t;
        @(posedge clock);
        #1;
        ma = step(ma, v, h, t, 16, 255);
        mb = step(mb, v, h, t, 4, 3);
        check_all();
    endtask

    task automatic do_reset();
        valid = 1'b0;
        head  = 1'b0;
        tail  = 1'b0;
        reset = 1'b1;
        #2;
        ma = model_reset();
        mb = model_reset();
        check_all();
        check("a.pkt_len_rst", int'(a_plen), 0);
        check("b.pkt_len_rst", int'(b_plen), 0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Beat shorthands: head-only, data, tail-only, single-beat packet, idle.
    task automatic bh(); beat(1, 1, 0); endtask
    task automatic bd(); beat(1, 0, 0); endtask
    task automatic bt(); beat(1, 0, 1); endtask
    task automatic bs(); beat(1, 1, 1); endtask
    task automatic bi(); beat(0, 0, 0); endtask

    initial begin
        ma = model_reset();
        mb = model_reset();
        @(negedge clock);
        do_reset();

        bh(); bd(); bd(); bt(); bi();
        check("len4_packet", int'(a_pc), 1);

        bs(); bh(); bt(); bi();

        bd(); bd(); bd(); bh(); bt(); bi();

        bh(); bd(); bd(); bd(); bd(); bi();
        check("overlen_code_b", int'(b_code), 3);
        bh(); bd(); bd(); bt(); bi();

        do_reset();
        bh(); bd();
        do_reset();
        bd();
        check("reset_orphan_ec", int'(a_ec), 1);
        bi();

        for (int i = 0; i < 5; i++) begin
            bs();
            bi();
        end
        check("pkt_count_sat_b", int'(b_pc), 3);

        bh(); bh(); bi();
        for (int i = 0; i < 17; i++) bd();
        bi();
        bh();
        for (int i = 0; i < 14; i++) bd();
        bt(); bi();

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                beat($urandom_range(0, 3) != 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
